// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between the instruction-fetch
// port and the data (load/store) port. One access at a time is registered onto
// the memory bus; completion is signalled by a one-cycle valid pulse, and a
// memory that never answers is abandoned after TIMEOUT cycles with an err pulse.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_func3,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // Memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Core control
  output logic              stall,
  output logic              err
);

  // Counter only needs to reach TIMEOUT-1; TIMEOUT >= 2 keeps CntW >= 1.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  // Fetches are always full-word accesses.
  localparam logic [2:0] Func3Word = 3'b010;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeD = 2'd1,
    StServeI = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;

  logic serving_d;
  logic d_grant;
  logic if_grant;

  // A port whose valid is high this cycle is still holding its old request,
  // so that request must not be granted a second time.
  assign d_grant   = d_req & ~d_valid_q;
  assign if_grant  = if_req & ~if_valid_q;
  assign serving_d = (state_q == StServeD);

  // Next-state logic: grant in idle, wait for ready or timeout while serving.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Data first: it belongs to an older instruction than the fetch.
        if (d_grant) begin
          state_d = StServeD;
          cnt_d   = '0;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          func3_d = d_func3;
        end else if (if_grant) begin
          state_d = StServeI;
          cnt_d   = '0;
          we_d    = 1'b0;
          addr_d  = if_addr;
          func3_d = Func3Word;
        end
      end

      StServeD, StServeI: begin
        if (mem_ready) begin
          state_d = StIdle;
          if (serving_d) begin
            d_valid_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          // Memory never answered: release the requester with zero data.
          state_d = StIdle;
          err_d   = 1'b1;
          if (serving_d) begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      func3_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      func3_q    <= func3_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
    end
  end

  // Output drive: bus fields come straight from the latched request.
  always_comb begin
    mem_req   = (state_q != StIdle);
    mem_we    = serving_d & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_func3 = func3_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if_valid  = if_valid_q;
    d_valid   = d_valid_q;
    err       = err_q;
    stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter. A transaction-level model tracks
// the outstanding access (which port, its fields, how long memory will take)
// and predicts every output each cycle.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam int NumCycles   = 6000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_func3;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall;
  logic          err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_func3   (d_func3),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .err       (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Contents of the simulated memory: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory response latency in cycles after mem_req rises; huge means never.
  function automatic int pick_latency();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6)       return int'($urandom_range(0, 3));
    else if (r == 6) return TO - 1;  // ready on the very last allowed cycle
    else if (r == 7) return TO - 2;
    else             return 100000;  // never answers -> timeout
  endfunction

  // Model: the access in flight and the values the outputs must show now.
  bit            m_busy;
  bit            m_is_d;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_func3;
  int            m_elapsed;
  int            m_lat;
  bit            m_if_valid;
  bit            m_d_valid;
  bit            m_err;
  logic [DW-1:0] m_if_rdata;
  logic [DW-1:0] m_d_rdata;
  bit            m_bus_reset;  // bus fields still at reset value, no grant since
  bit            prv_if_valid;
  bit            prv_d_valid;

  task automatic model_reset();
    m_busy      = 0;
    m_is_d      = 0;
    m_we        = 0;
    m_addr      = '0;
    m_wdata     = '0;
    m_func3     = '0;
    m_elapsed   = 0;
    m_lat       = 0;
    m_if_valid  = 0;
    m_d_valid   = 0;
    m_err       = 0;
    m_if_rdata  = '0;
    m_d_rdata   = '0;
    m_bus_reset = 1;
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_func3   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    prv_if_valid = 0;
    prv_d_valid  = 0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      #1;

      // Requesters and reset for this cycle.
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (rst) begin
        d_req  = 1'b0;
        if_req = 1'b0;
      end else begin
        if (d_req && prv_d_valid) d_req = 1'b0;
        if (if_req && prv_if_valid) if_req = 1'b0;
        if (!d_req && (cyc > 20) && ($urandom_range(0, 2) == 0)) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_func3 = 3'($urandom_range(0, 7));
        end
        if (!if_req && (cyc > 20) && ($urandom_range(0, 1) == 0)) begin
          if_req  = 1'b1;
          if_addr = $urandom;
        end
      end
      if (!d_req) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = 1'($urandom_range(0, 1));
      end
      if (!if_req) if_addr = $urandom;

      // Memory responder: noise while idle, scheduled ready while busy.
      if (m_busy && !rst) begin
        mem_ready = (m_elapsed == m_lat);
        mem_rdata = mem_ready ? mem_word(m_addr) : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end

      #3;
      check_eq("mem_req", mem_req, m_busy);
      check_eq("mem_we", mem_we, m_busy && m_is_d && m_we);
      if (m_busy || m_bus_reset) begin
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_func3", mem_func3, m_func3);
      end
      if ((m_busy && m_is_d) || m_bus_reset) check_eq("mem_wdata", mem_wdata, m_wdata);
      check_eq("if_valid", if_valid, m_if_valid);
      check_eq("d_valid", d_valid, m_d_valid);
      check_eq("err", err, m_err);
      check_eq("if_rdata", if_rdata, m_if_rdata);
      check_eq("d_rdata", d_rdata, m_d_rdata);
      check_eq("stall", stall, (if_req && !m_if_valid) || (d_req && !m_d_valid));

      // Advance the model to what the next cycle must show.
      prv_if_valid = m_if_valid;
      prv_d_valid  = m_d_valid;
      if (rst) begin
        model_reset();
      end else begin
        bit cur_if_valid;
        bit cur_d_valid;
        cur_if_valid = m_if_valid;
        cur_d_valid  = m_d_valid;
        m_if_valid   = 0;
        m_d_valid    = 0;
        m_err        = 0;
        if (m_busy) begin
          if (mem_ready) begin
            m_busy = 0;
            if (m_is_d) begin
              m_d_valid = 1;
              if (!m_we) m_d_rdata = mem_word(m_addr);
            end else begin
              m_if_valid = 1;
              m_if_rdata = mem_word(m_addr);
            end
          end else if (m_elapsed == TO - 1) begin
            m_busy = 0;
            m_err  = 1;
            if (m_is_d) begin
              m_d_valid = 1;
              m_d_rdata = '0;
            end else begin
              m_if_valid = 1;
              m_if_rdata = '0;
            end
          end else begin
            m_elapsed++;
          end
        end else if (d_req && !cur_d_valid) begin
          m_busy      = 1;
          m_is_d      = 1;
          m_we        = d_we;
          m_addr      = d_addr;
          m_wdata     = d_wdata;
          m_func3     = d_func3;
          m_elapsed   = 0;
          m_lat       = pick_latency();
          m_bus_reset = 0;
        end else if (if_req && !cur_if_valid) begin
          m_busy      = 1;
          m_is_d      = 0;
          m_we        = 0;
          m_addr      = if_addr;
          m_func3     = 3'b010;
          m_elapsed   = 0;
          m_lat       = pick_latency();
          m_bus_reset = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified memory between the core's instruction-fetch port and data (load/store) port. It turns the separate instruction and data memories into one memory that is accessed over several cycles. The block grants one requester at a time and registers the winning address, data and control onto the memory bus. It waits for the memory's ready, returns read data with a one-cycle valid pulse, and recovers from a memory that never answers via a timeout. The block sits between the fetch/load-store logic and the memory, and drives the core's global stall.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ready (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, held until next fetch completion
- if_valid  out  1  one-cycle fetch-done pulse
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_func3  in  3  access size/sign, passed to memory unchanged
- d_rdata  out  DATA_W  load data, held until next load completion
- d_valid  out  1  one-cycle data-done pulse
- mem_req  out  1  memory access active
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_func3  out  3  registered size; 3'b010 for fetches
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- stall  out  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid)
- err  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, SERVE_D, SERVE_I.
- IDLE: a port's req is ignored in any cycle where that port's valid is high.
  - If d_req is high, latch d_addr/d_wdata/d_we/d_func3 and go to SERVE_D.
  - Else if if_req is high, latch if_addr, set we=0 and func3=3'b010, and go to SERVE_I.
  - Data has fixed priority over fetch: a data access belongs to the older instruction.
- SERVE_x: mem_req=1 and the mem_* outputs stay constant for the whole state.
  - mem_ready=1 → return to IDLE and pulse x_valid next cycle.
  - On a read, capture mem_rdata into x_rdata.
  - On a store, d_rdata is unchanged.
- Timeout: counter cleared on entry to SERVE_x and incremented each cycle that mem_ready=0.
  - mem_ready=0 on the cycle the counter equals TIMEOUT-1 → go to IDLE.
  - Next cycle, pulse x_valid and err together, and x_rdata becomes 0.
- mem_ready seen in IDLE is ignored.
- Write with ready: mem_we is high only while in SERVE_D with a latched store.

## Timing
- Reset values, visible the cycle after rst is sampled high:
  - state=IDLE, counter=0.
  - mem_req, mem_we, if_valid, d_valid and err = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
  - mem_func3 = 0.
- Reset mid-access aborts it: no valid pulse and no err.
- Minimum latency: req sampled at cycle N → mem_req at N+1 → mem_ready at N+1 → valid at N+2.
- General latency: valid arrives 1 cycle after mem_ready.
- Back-to-back: a requester may present a new req in cycle valid+1.
  - The earliest new mem_req is valid+2.
- Both reqs high in IDLE: data is served first.
  - The fetch is granted in the first IDLE cycle after d_valid in which d_req is low or ignored.
  - With a pending fetch, memory therefore never grants data twice consecutively unless d_req re-asserts after its valid cycle.
- Timeout: with mem_ready stuck at 0, mem_req stays high for exactly TIMEOUT cycles; err and valid arrive on the following cycle.
- if_valid and d_valid are never high in the same cycle.

## Test plan
- Reset then idle: rst 2 cycles, no reqs → all outputs 0, stall=0, mem_req never rises.
- Single fetch, ready immediate: if_req, if_addr=0x40 at cycle 1; memory returns 0x00500093 with mem_ready at cycle 2.
  - mem_addr=0x40 and mem_func3=3'b010 at cycle 2.
  - if_valid=1 and if_rdata=0x00500093 at cycle 3.
  - stall high cycles 1–2.
- Collision: d_req (load, addr 0x100, func3 3'b000) and if_req (0x44) together, memory ready after 2 cycles each.
  - Load is served first and d_valid fires before if_valid.
  - Fetch mem_req rises 1 cycle after d_valid.
  - Each valid is a single-cycle pulse.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF → mem_we=1 with mem_wdata=0xDEADBEEF while mem_req is high; d_valid pulses and d_rdata is unchanged.
- Timeout: TIMEOUT=16, mem_ready tied 0, fetch 0x80 → mem_req high exactly 16 cycles, then if_valid=err=1 for one cycle with if_rdata=0 and FSM back in IDLE.
- Reset mid-access: assert rst while in SERVE_D with mem_ready low → mem_req=0 next cycle, and neither d_valid nor err ever pulses for that access.
